// File: rtl/fifo_pkg.sv
// Shared FIFO constants and pointer type for the same-clock and dual-clock FIFO models.
package fifo_pkg;

  localparam int FIFO_DSIZE_DEF     = 8;
  localparam int FIFO_ASIZE_DEF     = 4;
  localparam int FIFO_AFULL_TH_DEF  = 2**FIFO_ASIZE_DEF - 2;
  localparam int FIFO_AEMPTY_TH_DEF = 2;

  // Binary pointer for the default depth: the extra MSB is the wrap bit.
  typedef logic [FIFO_ASIZE_DEF:0] fifo_ptr_t;

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage array: one synchronous write port, one asynchronous read port.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DSIZE = FIFO_DSIZE_DEF,
  parameter int ASIZE = FIFO_ASIZE_DEF
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [ASIZE-1:0] waddr_i,
  input  logic [DSIZE-1:0] wdata_i,
  input  logic [ASIZE-1:0] raddr_i,
  output logic [DSIZE-1:0] rdata_o
);

  logic [DSIZE-1:0] mem_q [2**ASIZE];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, threshold flags and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through; otherwise rdata is registered.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DSIZE     = FIFO_DSIZE_DEF,
  parameter int ASIZE     = FIFO_ASIZE_DEF,
  parameter int AFULL_TH  = 2**ASIZE - 2,
  parameter int AEMPTY_TH = FIFO_AEMPTY_TH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             wfull,
  output logic             rempty,
  output logic             wafull,
  output logic             raempty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow
);

  typedef logic [ASIZE:0] ptr_t;

  localparam ptr_t AFULL_C  = ptr_t'(AFULL_TH);
  localparam ptr_t AEMPTY_C = ptr_t'(AEMPTY_TH);

  ptr_t             wptr_q, wptr_d;
  ptr_t             rptr_q, rptr_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             wr_acc, rd_acc;
  logic [DSIZE-1:0] mem_rdata;

  // A write into a full FIFO is refused even when a read frees a slot on the same edge.
  always_comb begin
    wr_acc = winc & ~wfull;
    rd_acc = rinc & ~rempty;
    wptr_d = wptr_q + ptr_t'(wr_acc);
    rptr_d = rptr_q + ptr_t'(rd_acc);
    ovf_d  = ovf_q | (winc & wfull);
    udf_d  = udf_q | (rinc & rempty);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
    end
  end

  fifo_mem #(
    .DSIZE(DSIZE),
    .ASIZE(ASIZE)
  ) u_mem (
    .clk    (clk),
    .we_i   (wr_acc & ~rst),
    .waddr_i(wptr_q[ASIZE-1:0]),
    .wdata_i(wdata),
    .raddr_i(rptr_q[ASIZE-1:0]),
    .rdata_o(mem_rdata)
  );

  // Modulo subtraction keeps count correct across any number of pointer wraps.
  assign count     = wptr_q - rptr_q;
  assign rempty    = (wptr_q == rptr_q);
  assign wfull     = (wptr_q[ASIZE-1:0] == rptr_q[ASIZE-1:0]) &&
                     (wptr_q[ASIZE] != rptr_q[ASIZE]);
  assign wafull    = (count >= AFULL_C);
  assign raempty   = (count <= AEMPTY_C);
  assign overflow  = ovf_q;
  assign underflow = udf_q;

`ifdef SYNC_FIFO_FWFT_EN
  assign rdata = rempty ? '0 : mem_rdata;
`else
  logic [DSIZE-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (rd_acc) begin
      rdata_q <= mem_rdata;
    end
  end

  assign rdata = rdata_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo (depth 4, AFULL_TH=3, AEMPTY_TH=1).
module tb_sync_fifo;

  logic       clk;
  logic       rst;
  logic       winc;
  logic [7:0] wdata;
  logic       rinc;
  logic [7:0] rdata;
  logic       wfull, rempty, wafull, raempty;
  logic [2:0] count;
  logic       overflow, underflow;

  int checks = 0;
  int errors = 0;

  sync_fifo #(
    .DSIZE    (8),
    .ASIZE    (2),
    .AFULL_TH (3),
    .AEMPTY_TH(1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .winc     (winc),
    .wdata    (wdata),
    .rinc     (rinc),
    .rdata    (rdata),
    .wfull    (wfull),
    .rempty   (rempty),
    .wafull   (wafull),
    .raempty  (raempty),
    .count    (count),
    .overflow (overflow),
    .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [7:0] d);
    winc  = 1'b1;
    wdata = d;
    tick();
    winc  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if ({rempty, raempty, wfull, wafull} !== 4'b1100) begin errors++; $display("FAIL reset_flags: got %b expected 1100", {rempty, raempty, wfull, wafull}); end
    checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL reset_err: got %b expected 00", {overflow, underflow}); end
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h expected 00", rdata); end
  endtask

  task automatic test_fill();
    logic [3:0] exp_flags;
    for (int i = 0; i < 4; i++) begin
      write_word(8'hA0 + 8'(i));
      exp_flags = {(i + 1 >= 3), (i + 1 == 4), (i + 1 <= 1), 1'b0};
      checks++; if (count !== 3'(i + 1)) begin errors++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, count, i + 1); end
      checks++; if ({wafull, wfull, raempty, rempty} !== exp_flags) begin errors++; $display("FAIL fill_flags[%0d]: got %b expected %b", i, {wafull, wfull, raempty, rempty}, exp_flags); end
    end
  endtask

  task automatic test_overflow_drain();
    write_word(8'hFF);
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL ovf_count: got %0d expected 4", count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
    for (int i = 0; i < 4; i++) begin
      rinc = 1'b1;
`ifdef SYNC_FIFO_FWFT_EN
      checks++; if (rdata !== 8'hA0 + 8'(i)) begin errors++; $display("FAIL drain_data[%0d]: got %h expected %h", i, rdata, 8'hA0 + 8'(i)); end
      tick();
`else
      tick();
      checks++; if (rdata !== 8'hA0 + 8'(i)) begin errors++; $display("FAIL drain_data[%0d]: got %h expected %h", i, rdata, 8'hA0 + 8'(i)); end
`endif
      rinc = 1'b0;
    end
    checks++; if ({count, rempty} !== {3'd0, 1'b1}) begin errors++; $display("FAIL drain_end: got count %0d rempty %b expected 0 1", count, rempty); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
  endtask

  task automatic test_underflow();
    rinc = 1'b1;
    tick();
    rinc = 1'b0;
    checks++; if ({rempty, underflow, count} !== {1'b1, 1'b1, 3'd0}) begin errors++; $display("FAIL udf: got rempty %b udf %b count %0d expected 1 1 0", rempty, underflow, count); end
    write_word(8'h33);
    rinc = 1'b1;
`ifdef SYNC_FIFO_FWFT_EN
    checks++; if (rdata !== 8'h33) begin errors++; $display("FAIL udf_rptr: got %h expected 33", rdata); end
    tick();
`else
    tick();
    checks++; if (rdata !== 8'h33) begin errors++; $display("FAIL udf_rptr: got %h expected 33", rdata); end
`endif
    rinc = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL udf_count: got %0d expected 0", count); end
  endtask

  task automatic test_back_to_back();
    write_word(8'h10);
    write_word(8'h11);
    for (int i = 0; i < 10; i++) begin
      winc  = 1'b1;
      rinc  = 1'b1;
      wdata = 8'h12 + 8'(i);
`ifdef SYNC_FIFO_FWFT_EN
      checks++; if (rdata !== 8'h10 + 8'(i)) begin errors++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, rdata, 8'h10 + 8'(i)); end
      tick();
`else
      tick();
      checks++; if (rdata !== 8'h10 + 8'(i)) begin errors++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, rdata, 8'h10 + 8'(i)); end
`endif
      checks++; if (count !== 3'd2) begin errors++; $display("FAIL b2b_count[%0d]: got %0d expected 2", i, count); end
    end
    winc = 1'b0;
    for (int i = 0; i < 2; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
      checks++; if (rdata !== 8'h1A + 8'(i)) begin errors++; $display("FAIL b2b_tail[%0d]: got %h expected %h", i, rdata, 8'h1A + 8'(i)); end
      tick();
`else
      tick();
      checks++; if (rdata !== 8'h1A + 8'(i)) begin errors++; $display("FAIL b2b_tail[%0d]: got %h expected %h", i, rdata, 8'h1A + 8'(i)); end
`endif
    end
    rinc = 1'b0;
    checks++; if (rempty !== 1'b1) begin errors++; $display("FAIL b2b_empty: got %b expected 1", rempty); end
  endtask

  task automatic test_full_rw();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) write_word(8'hC0 + 8'(i));
    checks++; if ({wfull, overflow} !== 2'b10) begin errors++; $display("FAIL frw_pre: got %b expected 10", {wfull, overflow}); end
    winc  = 1'b1;
    rinc  = 1'b1;
    wdata = 8'hEE;
    tick();
    winc  = 1'b0;
    checks++; if ({count, overflow} !== {3'd3, 1'b1}) begin errors++; $display("FAIL frw_post: got count %0d ovf %b expected 3 1", count, overflow); end
`ifdef SYNC_FIFO_FWFT_EN
    checks++; if (rdata !== 8'hC1) begin errors++; $display("FAIL frw_data: got %h expected c1", rdata); end
`else
    checks++; if (rdata !== 8'hC0) begin errors++; $display("FAIL frw_data: got %h expected c0", rdata); end
`endif
    for (int i = 1; i < 4; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
      checks++; if (rdata !== 8'hC0 + 8'(i)) begin errors++; $display("FAIL frw_drain[%0d]: got %h expected %h", i, rdata, 8'hC0 + 8'(i)); end
      tick();
`else
      tick();
      checks++; if (rdata !== 8'hC0 + 8'(i)) begin errors++; $display("FAIL frw_drain[%0d]: got %h expected %h", i, rdata, 8'hC0 + 8'(i)); end
`endif
    end
    rinc = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL frw_end: got %0d expected 0", count); end
  endtask

  task automatic test_rst_mid();
    for (int i = 0; i < 3; i++) write_word(8'h70 + 8'(i));
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL rmid_pre: got %0d expected 3", count); end
    rst   = 1'b1;
    winc  = 1'b1;
    wdata = 8'h99;
    tick();
    rst   = 1'b0;
    winc  = 1'b0;
    checks++; if ({count, rempty} !== {3'd0, 1'b1}) begin errors++; $display("FAIL rmid_count: got count %0d rempty %b expected 0 1", count, rempty); end
    checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL rmid_err: got %b expected 00", {overflow, underflow}); end
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL rmid_rdata: got %h expected 00", rdata); end
    write_word(8'h5A);
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL rmid_wr: got %0d expected 1", count); end
`ifdef SYNC_FIFO_FWFT_EN
    checks++; if (rdata !== 8'h5A) begin errors++; $display("FAIL rmid_fwft: got %h expected 5a", rdata); end
`else
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL rmid_hold: got %h expected 00", rdata); end
    rinc = 1'b1;
    tick();
    rinc = 1'b0;
    checks++; if (rdata !== 8'h5A) begin errors++; $display("FAIL rmid_read: got %h expected 5a", rdata); end
`endif
  endtask

  initial begin
    rst   = 1'b1;
    winc  = 1'b0;
    rinc  = 1'b0;
    wdata = 8'h00;
    test_reset();
    test_fill();
    test_overflow_drain();
    test_underflow();
    test_back_to_back();
    test_full_rw();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
